// File: rtl/reg_dump_pkg.sv
// Shared constants and state encoding for the register/character-memory dump streamer.
package reg_dump_pkg;

    localparam logic [7:0] HDR_BYTE   = 8'hA5;
    localparam logic [7:0] TRL_BYTE   = 8'h5A;
    localparam logic [7:0] CH_ID_REG  = 8'h01;
    localparam logic [7:0] CH_ID_CHAR = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        CH_ID,
        CH_CNT,
        RD,
        LATCH,
        SEND,
        TRAIL
    } state_t;

endpackage

// File: rtl/word_byte_serializer.sv
// Loads a word plus a byte count and emits it LSB-first on a valid/ready handshake.
module word_byte_serializer #(
    parameter int  DATA_W = 32,
    localparam int CNT_W  = $clog2(DATA_W / 8 + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] load_word,
    input  logic [CNT_W-1:0]  load_cnt,
    input  logic              ready,
    output logic              valid,
    output logic [7:0]        data,
    output logic              last
);

    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  rem;

    // rem is a down-counter of bytes still owed; zero means empty.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shreg <= '0;
            rem   <= '0;
        end else if (clear) begin
            shreg <= '0;
            rem   <= '0;
        end else if (load) begin
            shreg <= load_word;
            rem   <= load_cnt;
        end else if (valid && ready) begin
            shreg <= shreg >> 8;
            rem   <= rem - 1'b1;
        end
    end

    assign valid = (rem != '0);
    assign data  = shreg[7:0];
    assign last  = (rem == CNT_W'(1));

endmodule

// File: rtl/reg_dump_streamer.sv
// Streams a framed dump of the register file and/or character memory as bytes.
//
// state  | meaning
// IDLE   | waiting for start
// HDR    | sending frame header byte
// CH_ID  | sending channel ID byte
// CH_CNT | sending channel entry count
// RD     | one-cycle read enable for current index
// LATCH  | read data captured into serializer
// SEND   | serializer emitting entry bytes
// TRAIL  | sending trailer byte, done on transfer
module reg_dump_streamer
    import reg_dump_pkg::*;
#(
    parameter int  DATA_W   = 32,
    parameter int  NUM_REGS = 32,
    parameter int  NUM_CHAR = 19,
    parameter int  CHAR_W   = 8,
    localparam int RF_AW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int CM_AW    = (NUM_CHAR > 1) ? $clog2(NUM_CHAR) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [1:0]        chan_mask,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              rf_ren,
    output logic [RF_AW-1:0]  rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              cm_ren,
    output logic [CM_AW-1:0]  cm_raddr,
    input  logic [CHAR_W-1:0] cm_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int NBYTES = DATA_W / 8;
    localparam int CNT_W  = $clog2(NBYTES + 1);

    state_t      state_q, state_d;
    logic        chan_q, chan_d;
    logic [1:0]  mask_q, mask_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  last_idx;

    logic              ser_load;
    logic              ser_clear;
    logic              ser_ready;
    logic [DATA_W-1:0] ser_word;
    logic [CNT_W-1:0]  ser_cnt;
    logic              ser_valid;
    logic [7:0]        ser_data;
    logic              ser_last;

    assign busy      = (state_q != IDLE);
    assign last_idx  = chan_q ? 8'(NUM_CHAR - 1) : 8'(NUM_REGS - 1);
    assign rf_raddr  = idx_q[RF_AW-1:0];
    assign cm_raddr  = idx_q[CM_AW-1:0];
    assign ser_word  = chan_q ? DATA_W'(cm_rdata) : rf_rdata;
    assign ser_cnt   = chan_q ? CNT_W'(1) : CNT_W'(NBYTES);
    assign ser_clear = abort && busy;
    assign ser_ready = (state_q == SEND) && tx_ready && !abort;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            chan_q  <= 1'b0;
            mask_q  <= 2'b00;
            idx_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        mask_d   = mask_q;
        idx_d    = idx_q;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        rf_ren   = 1'b0;
        cm_ren   = 1'b0;
        done     = 1'b0;
        ser_load = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = HDR;
                    mask_d  = chan_mask;
                    chan_d  = 1'b0;
                    idx_d   = 8'd0;
                end
            end
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = HDR_BYTE;
                if (tx_ready) begin
                    if (mask_q[0]) begin
                        chan_d  = 1'b0;
                        state_d = CH_ID;
                    end else if (mask_q[1]) begin
                        chan_d  = 1'b1;
                        state_d = CH_ID;
                    end else begin
                        state_d = TRAIL;
                    end
                end
            end
            CH_ID: begin
                tx_valid = 1'b1;
                tx_data  = chan_q ? CH_ID_CHAR : CH_ID_REG;
                if (tx_ready) state_d = CH_CNT;
            end
            CH_CNT: begin
                tx_valid = 1'b1;
                tx_data  = chan_q ? 8'(NUM_CHAR) : 8'(NUM_REGS);
                if (tx_ready) begin
                    idx_d   = 8'd0;
                    state_d = RD;
                end
            end
            RD: begin
                rf_ren  = !chan_q;
                cm_ren  = chan_q;
                state_d = LATCH;
            end
            LATCH: begin
                ser_load = 1'b1;
                state_d  = SEND;
            end
            SEND: begin
                tx_valid = ser_valid;
                tx_data  = ser_data;
                if (ser_valid && ser_last && tx_ready) begin
                    if (idx_q == last_idx) begin
                        idx_d = 8'd0;
                        if (!chan_q && mask_q[1]) begin
                            chan_d  = 1'b1;
                            state_d = CH_ID;
                        end else begin
                            state_d = TRAIL;
                        end
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = RD;
                    end
                end
            end
            TRAIL: begin
                tx_valid = 1'b1;
                tx_data  = TRL_BYTE;
                if (tx_ready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort suppresses the handshake this cycle so no partial byte is counted.
        if (abort && (state_q != IDLE)) begin
            state_d  = IDLE;
            idx_d    = 8'd0;
            tx_valid = 1'b0;
            done     = 1'b0;
            ser_load = 1'b0;
        end
    end

    word_byte_serializer #(
        .DATA_W (DATA_W)
    ) u_ser (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (ser_clear),
        .load      (ser_load),
        .load_word (ser_word),
        .load_cnt  (ser_cnt),
        .ready     (ser_ready),
        .valid     (ser_valid),
        .data      (ser_data),
        .last      (ser_last)
    );

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Scoreboard bench: expected frames queued at start, monitor pops on each transferred byte.
module tb_reg_dump_streamer;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int NUM_CHAR = 19;
    localparam int CHAR_W   = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  chan_mask = 2'b00;
    logic        abort = 1'b0;
    logic        busy, done;
    logic        rf_ren, cm_ren;
    logic [4:0]  rf_raddr, cm_raddr;
    logic [DATA_W-1:0] rf_rdata = '0;
    logic [CHAR_W-1:0] cm_rdata = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    reg_dump_streamer #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_CHAR(NUM_CHAR), .CHAR_W(CHAR_W)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .chan_mask(chan_mask), .abort(abort),
        .busy(busy), .done(done),
        .rf_ren(rf_ren), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .cm_ren(cm_ren), .cm_raddr(cm_raddr), .cm_rdata(cm_rdata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    logic [31:0] rf_mem [NUM_REGS];
    logic [7:0]  cm_mem [NUM_CHAR];

    always @(posedge clk) begin
        if (rf_ren) rf_rdata <= rf_mem[rf_raddr];
        if (cm_ren) cm_rdata <= cm_mem[cm_raddr];
    end

    typedef struct {
        logic [7:0] b;
        bit         last;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] log_q[$];
    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int rf_reads [NUM_REGS];
    int cm_reads [NUM_CHAR];
    bit rand_ready = 1'b0;

    initial begin
        for (int i = 0; i < NUM_REGS; i++) rf_reads[i] = 0;
        for (int i = 0; i < NUM_CHAR; i++) cm_reads[i] = 0;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: handshakes are sampled on the falling edge and commit at the next rising edge.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    always @(negedge clk) begin
        bit   popped_last;
        exp_t e;
        popped_last = 1'b0;
        if (!resetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && tx_valid) begin
                tests++;
                if (tx_data !== prev_data) begin
                    fails++;
                    $display("FAIL stall_hold: tx_data=%02h required %02h", tx_data, prev_data);
                end
            end
            if (rf_ren || cm_ren) begin
                tests++;
                if (rf_ren && cm_ren) begin
                    fails++;
                    $display("FAIL ren_exclusive: rf_ren=%0b cm_ren=%0b required not both", rf_ren, cm_ren);
                end
            end
            if (rf_ren) rf_reads[rf_raddr]++;
            if (cm_ren && cm_raddr < NUM_CHAR) cm_reads[cm_raddr]++;
            if (tx_valid && tx_ready) begin
                log_q.push_back(tx_data);
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL stream_byte: got unexpected %02h required none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    popped_last = e.last;
                    if (tx_data !== e.b) begin
                        fails++;
                        $display("FAIL stream_byte: got %02h required %02h", tx_data, e.b);
                    end
                end
            end
            if (done) done_cnt++;
            if (done || popped_last) begin
                tests++;
                if (done !== popped_last) begin
                    fails++;
                    $display("FAIL done_timing: done=%0b required %0b", done, popped_last);
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push_b(input logic [7:0] b, input bit last);
        exp_t e;
        e.b = b;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input logic [1:0] m);
        push_b(8'hA5, 1'b0);
        if (m[0]) begin
            push_b(8'h01, 1'b0);
            push_b(8'(NUM_REGS), 1'b0);
            for (int i = 0; i < NUM_REGS; i++)
                for (int k = 0; k < 4; k++) push_b(rf_mem[i][8*k +: 8], 1'b0);
        end
        if (m[1]) begin
            push_b(8'h02, 1'b0);
            push_b(8'(NUM_CHAR), 1'b0);
            for (int i = 0; i < NUM_CHAR; i++) push_b(cm_mem[i], 1'b0);
        end
        push_b(8'h5A, 1'b1);
    endtask

    task automatic pulse_start(input logic [1:0] m);
        @(posedge clk);
        #1;
        chan_mask = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("start_busy", busy, 1);
        check("start_hdr_valid", tx_valid, 1);
        check("start_hdr_data", tx_data, 8'hA5);
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_rf_ren", rf_ren, 0);
        check("rst_cm_ren", cm_ren, 0);
        check("rst_rf_raddr", rf_raddr, 0);
        check("rst_cm_raddr", cm_raddr, 0);
    endtask

    task automatic run_frame(input logic [1:0] m, output int s);
        int snap_rf [NUM_REGS];
        int snap_cm [NUM_CHAR];
        int base;
        int n;
        int bad;
        snap_rf = rf_reads;
        snap_cm = cm_reads;
        base = done_cnt;
        s = log_q.size();
        push_frame(m);
        pulse_start(m);
        n = 0;
        while (done_cnt == base && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("frame_completed", 32'(done_cnt != base), 1);
        @(negedge clk);
        check("frame_busy_after", busy, 0);
        check("frame_done_pulses", done_cnt - base, 1);
        check("frame_queue_empty", exp_q.size(), 0);
        bad = 0;
        for (int i = 0; i < NUM_REGS; i++)
            if (rf_reads[i] - snap_rf[i] != (m[0] ? 1 : 0)) bad++;
        for (int i = 0; i < NUM_CHAR; i++)
            if (cm_reads[i] - snap_cm[i] != (m[1] ? 1 : 0)) bad++;
        check("reads_per_entry", bad, 0);
        exp_q.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int n;
        int base;
        logic [7:0] s1_exp [11];
        logic [7:0] s2_exp [8];
        s1_exp = '{8'hA5, 8'h01, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        s2_exp = '{8'hA5, 8'h02, 8'h13, 8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

        for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = 32'h0;
        rf_mem[1] = 32'h12345678;
        for (int i = 0; i < NUM_CHAR; i++) cm_mem[i] = 8'h00;
        cm_mem[0] = 8'h48; cm_mem[1] = 8'h45; cm_mem[2] = 8'h4C; cm_mem[3] = 8'h4C; cm_mem[4] = 8'h4F;

        #2 resetn = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1 resetn = 1'b1;

        // Scenario 1: register file only
        run_frame(2'b01, s);
        check("s1_len", log_q.size() - s, 132);
        for (int k = 0; k < 11; k++) check("s1_bytes", log_q[s + k], s1_exp[k]);
        check("s1_trailer", log_q[s + 131], 8'h5A);

        // Scenario 2: character memory only
        run_frame(2'b10, s);
        check("s2_len", log_q.size() - s, 23);
        for (int k = 0; k < 8; k++) check("s2_bytes", log_q[s + k], s2_exp[k]);
        check("s2_trailer", log_q[s + 22], 8'h5A);

        // Scenario 4: empty mask
        run_frame(2'b00, s);
        check("s4_len", log_q.size() - s, 2);
        check("s4_hdr", log_q[s], 8'hA5);
        check("s4_trl", log_q[s + 1], 8'h5A);

        // Scenario 3: both channels, random backpressure
        rf_mem[0]  = 32'h000000FF;
        rf_mem[31] = 32'hDEADBEEF;
        rand_ready = 1'b1;
        run_frame(2'b11, s);
        check("s3_len", log_q.size() - s, 153);
        rand_ready = 1'b0;

        // Abort wins over same-cycle start in IDLE
        @(posedge clk);
        #1;
        chan_mask = 2'b01;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("abort_over_start_busy", busy, 0);
        check("abort_over_start_valid", tx_valid, 0);

        // Scenario 5: abort after ten bytes, then a fresh frame
        base = done_cnt;
        s = log_q.size();
        push_frame(2'b01);
        pulse_start(2'b01);
        n = 0;
        while (log_q.size() - s < 10 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        exp_q.delete();
        check("s5_bytes_before_abort", log_q.size() - s, 10);
        @(negedge clk);
        check("s5_busy", busy, 0);
        check("s5_tx_valid", tx_valid, 0);
        check("s5_rf_ren", rf_ren, 0);
        repeat (5) @(negedge clk);
        check("s5_no_done", done_cnt - base, 0);
        run_frame(2'b01, s);
        check("s5_len", log_q.size() - s, 132);
        for (int k = 0; k < 3; k++) check("s5_bytes", log_q[s + k], s1_exp[k]);

        // Scenario 6: reset mid-frame
        base = done_cnt;
        s = log_q.size();
        push_frame(2'b11);
        pulse_start(2'b11);
        n = 0;
        while (log_q.size() - s < 20 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        resetn = 1'b0;
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs();
        end
        @(posedge clk);
        #1 resetn = 1'b1;
        repeat (2) @(posedge clk);
        check("s6_no_done", done_cnt - base, 0);
        run_frame(2'b11, s);
        check("s6_len", log_q.size() - s, 153);
        check("s6_hdr", log_q[s], 8'hA5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_dump_streamer.md
REG_DUMP_STREAMER -- requirements
Module: reg_dump_streamer

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register word width; must be a multiple of 8.
REQ-002 SHALL have parameter NUM_REGS, default 32: register-file entries dumped; range 1..255.
REQ-003 SHALL have parameter NUM_CHAR, default 19: character-memory entries dumped; range 1..255.
REQ-004 SHALL have parameter CHAR_W, default 8: character width; range 1..8.
REQ-005 SHALL have the following ports:
  clk  in  1  sole clock, rising edge.
  resetn  in  1  asynchronous active-low reset.
  start  in  1  one-cycle request to begin a dump.
  chan_mask  in  2  channel enables: bit0 register file, bit1 character memory; sampled on accepted start.
  abort  in  1  cancel an active dump.
  busy  out  1  dump in progress.
  done  out  1  one-cycle pulse on normal completion.
  rf_ren  out  1  register-file read enable.
  rf_raddr  out  clog2(NUM_REGS)  register-file read address.
  rf_rdata  in  DATA_W  register-file data, valid one cycle after rf_ren.
  cm_ren  out  1  character-memory read enable.
  cm_raddr  out  clog2(NUM_CHAR)  character-memory read address.
  cm_rdata  in  CHAR_W  character data, valid one cycle after cm_ren.
  tx_data  out  8  stream byte.
  tx_valid  out  1  stream byte valid.
  tx_ready  in  1  sink ready.

Function
REQ-006 SHALL emit this frame: 0xA5; then, per enabled channel in order bit0 then bit1, a channel ID byte (0x01 reg, 0x02 char), a count byte (NUM_REGS or NUM_CHAR), and the entries from index 0 upward; then 0x5A.
REQ-007 SHALL emit each register entry as DATA_W/8 bytes, least-significant byte first.
REQ-008 SHALL emit each character entry as one byte, zero-extended from CHAR_W.
REQ-009 SHALL transfer a byte only on a cycle where tx_valid and tx_ready are both high.
REQ-010 SHALL hold tx_data stable while tx_valid is high and tx_ready is low, except on abort.
REQ-011 SHALL accept start only in IDLE; start while busy SHALL be ignored.
REQ-012 SHALL raise busy and tx_valid with tx_data = 0xA5 in the cycle after the start edge.
REQ-013 SHALL use FSM states IDLE, HDR, CH_ID, CH_CNT, RD, LATCH, SEND, TRAIL.
REQ-014 SHALL sequence RD -> LATCH -> SEND for each entry: RD pulses the read enable for one cycle with the index, LATCH captures the read data, and SEND serialises it.
REQ-015 SHALL start the next entry's read only after the last byte of the current entry has transferred.
REQ-016 SHALL, after the last byte of index NUM_x-1, go to the next enabled channel's CH_ID, or to TRAIL if none remains; the entry index SHALL reset to 0 per channel.
REQ-017 SHALL, with chan_mask == 0, emit only A5 5A and then pulse done.
REQ-018 SHALL, on the cycle the trailer transfers, pulse done for one cycle, drop busy and tx_valid, and return to IDLE.
REQ-019 SHALL, with tx_ready held low, stall indefinitely without losing data or re-reading the source.
REQ-020 SHALL, on abort while busy, return to IDLE on the next edge with tx_valid, busy and the read enables low and no done pulse; abort in IDLE has no effect.
REQ-021 SHALL let abort win over a same-cycle start.
REQ-022 SHALL never assert rf_ren and cm_ren in the same cycle.

Reset
REQ-023 SHALL, while resetn is low, force IDLE, busy=0, done=0, tx_valid=0, tx_data=0, rf_ren=0, cm_ren=0, rf_raddr=0, cm_raddr=0, and clear the index, byte counter and latched data, regardless of clock.
REQ-024 SHALL, if reset asserts mid-frame, discard the frame, and the first start after release SHALL produce a complete new frame.

Structure
REQ-025 SHALL keep the header (0xA5), trailer (0x5A), channel IDs and the FSM state enum in shared package reg_dump_pkg.
REQ-026 SHALL contain one sub-module, word_byte_serializer: it loads a DATA_W word plus a byte count and emits bytes LSB-first on the valid/ready handshake.

Verification
REQ-027 Scenario 1: reg model x1=0x12345678, others 0; mask=01; tx_ready=1 -> stream A5 01 20, 00 00 00 00, 78 56 34 12, ..., 5A; 132 bytes total; one done pulse.
REQ-028 Scenario 2: char memory "HELLO" then zeros; mask=10 -> A5 02 13 48 45 4C 4C 4F, then 14 x 00, then 5A; 23 bytes total.
REQ-029 Scenario 3: mask=11; tx_ready random at 50% -> byte sequence identical to the ungated run; tx_data never changes while stalled; exactly one read per entry.
REQ-030 Scenario 4: mask=00 -> A5 5A, then done; no read enables ever asserted.
REQ-031 Scenario 5: abort after byte 10, then start with mask=01 -> fresh frame beginning A5 01 20; no done pulse for the aborted frame.
REQ-032 Scenario 6: resetn low mid-frame, then a start 3 cycles after release -> outputs hold reset values during reset; the new frame is complete and correct.
